// File: rtl/gin_pkg.sv
// Shared GIN configuration: payload width, ID widths and PE array geometry.
// Also holds the state type that gin_bus reports on its debug output.
package gin_pkg;

    localparam int DATA_BITS   = 8;
    localparam int XID_BITS    = 4;
    localparam int YID_BITS    = 4;
    localparam int NUMS_PE_ROW = 4;
    localparam int NUMS_PE_COL = 4;

    typedef enum logic {
        GIN_IDLE  = 1'b0,
        GIN_BCAST = 1'b1
    } gin_state_e;

endpackage

// File: rtl/gin_id_chain.sv
// Scan-configured slave ID registers and the tag match vector.
// The match always uses the IDs held before any same-cycle shift.
module gin_id_chain #(
    parameter int NUMS    = 4,
    parameter int ID_BITS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set_id,
    input  logic [ID_BITS-1:0] scan_in,
    input  logic [ID_BITS-1:0] tag,
    output logic [ID_BITS-1:0] scan_out,
    output logic [NUMS-1:0]    match
);

    logic [ID_BITS-1:0] id_q [NUMS];
    logic [ID_BITS-1:0] id_d [NUMS];

    always_comb begin
        for (int i = 0; i < NUMS; i++) begin
            id_d[i] = id_q[i];
        end
        if (set_id) begin
            id_d[0] = scan_in;
            for (int i = 1; i < NUMS; i++) begin
                id_d[i] = id_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUMS; i++) begin
                id_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUMS; i++) begin
                id_q[i] <= id_d[i];
            end
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < NUMS; i++) begin
            match[i] = (id_q[i] == tag);
        end
    end

    assign scan_out = id_q[NUMS-1];

endmodule

// File: rtl/gin_bus.sv
// One GIN level: tag-addressed multicast from one master to NUMS_SLAVE slaves.
// The FSM state is implied by the pending mask: IDLE when empty, BCAST otherwise.
module gin_bus
    import gin_pkg::*;
#(
    parameter int NUMS_SLAVE = 4,
    parameter int ID_BITS    = 4,
    parameter int DATA_BITS  = gin_pkg::DATA_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ID_BITS-1:0]           tag,
    input  logic                         master_valid,
    output logic                         master_ready,
    input  logic [DATA_BITS-1:0]         master_data,
    output logic [NUMS_SLAVE-1:0]        slave_valid,
    input  logic [NUMS_SLAVE-1:0]        slave_ready,
    output logic [DATA_BITS*NUMS_SLAVE-1:0] slave_data,
    input  logic                         set_id,
    input  logic [ID_BITS-1:0]           ID_scan_in,
    output logic [ID_BITS-1:0]           ID_scan_out,
    output gin_state_e                   state_dbg
);

    // Handshake: a word moves on any interface in a cycle where valid and
    // ready are both high at the rising edge; valid never drops until ready.

    logic [NUMS_SLAVE-1:0] pending_q, pending_d;
    logic [DATA_BITS-1:0]  data_q, data_d;
    logic [NUMS_SLAVE-1:0] match;
    logic                  accept;

    gin_id_chain #(
        .NUMS    (NUMS_SLAVE),
        .ID_BITS (ID_BITS)
    ) u_id_chain (
        .clk      (clk),
        .rst      (rst),
        .set_id   (set_id),
        .scan_in  (ID_scan_in),
        .tag      (tag),
        .scan_out (ID_scan_out),
        .match    (match)
    );

    // Ready once every outstanding slave is either done or accepting now.
    assign master_ready = !rst && ((pending_q & ~slave_ready) == '0);
    assign accept       = master_valid && master_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            data_q    <= '0;
        end else begin
            pending_q <= pending_d;
            data_q    <= data_d;
        end
    end

    always_comb begin
        pending_d = pending_q & ~slave_ready;
        data_d    = data_q;
        if (accept) begin
            pending_d = match;
            data_d    = master_data;
        end
    end

    always_comb begin
        state_dbg   = (pending_q != '0) ? GIN_BCAST : GIN_IDLE;
        slave_valid = pending_q;
        slave_data  = {NUMS_SLAVE{data_q}};
    end

endmodule
